// File: rtl/carryadd_stage.sv
// Operand staging FIFO and result capture register around an external
// combinational adder; also keeps a saturating count of carry-out events.
module carryadd_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [15:0]      ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             load;
  logic             carry_next;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and in_ready never depends on
  // out_ready in the same cycle.
  always_comb begin
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    in_ready   = !full;
    push       = in_valid && !full;
    load       = !empty && (!out_valid || out_ready);
    add_a      = empty ? '0 : mem_a[rd_ptr[AW-1:0]];
    add_b      = empty ? '0 : mem_b[rd_ptr[AW-1:0]];
    // A wrapped sum is always smaller than either operand.
    carry_next = (add_y < add_a);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr[AW-1:0]] <= in_a;
      mem_b[wr_ptr[AW-1:0]] <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      ovf_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (load) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        out_sum   <= add_y;
        out_carry <= carry_next;
        out_valid <= 1'b1;
        if (carry_next && (ovf_count != 16'hFFFF)) ovf_count <= ovf_count + 16'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/carryadd_stage.md
# carryadd_stage

Operand staging and result capture stage that wraps the combinational `carryadd` ripple adder. It accepts operand pairs over a valid/ready handshake, buffers them in a small FIFO, and presents the head pair to the adder. It registers the adder's sum together with a derived carry-out flag onto a valid/ready output port, and keeps a saturating count of carry-out events. Sits between the operand producer and the result consumer; the adder instance is external and connects through `add_a`/`add_b`/`add_y`.

## Interface

Parameters:
- `WIDTH`, 8: operand/sum width; must equal the connected adder's `WIDTH`.
- `DEPTH`, 2: operand FIFO depth; power of two, 2..16.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  FIFO can accept a pair.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `add_a`  out  WIDTH  head operand A to adder `a`.
- `add_b`  out  WIDTH  head operand B to adder `b`.
- `add_y`  in  WIDTH  adder result `y`, combinational from `add_a`/`add_b`.
- `out_valid`  out  1  result register valid.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  WIDTH  registered sum, (a+b) mod 2^WIDTH.
- `out_carry`  out  1  registered carry-out of that sum.
- `ovf_count`  out  16  saturating count of results with carry set.

## Operation

- FIFO: `DEPTH` entries of {a,b}, with read/write pointers of log2(DEPTH)+1 bits. Full when pointers differ only in the MSB. Empty when the pointers are equal.
- `in_ready = !full`. It does not depend on a same-cycle pop, so there is no combinational path from `out_ready` to `in_ready`.
- Push when `in_valid && in_ready`. Data is written at the write pointer, then the pointer increments and wraps modulo 2·DEPTH.
- `add_a`/`add_b` drive the head entry combinationally. They are forced to 0 when the FIFO is empty.
- Load condition: `load = !empty && (!out_valid || out_ready)`.
- On load:
  - `out_sum <= add_y`.
  - `out_carry <= (add_y < add_a)`, an unsigned WIDTH-bit compare.
  - `out_valid <= 1`.
  - Pop the head.
- When `out_valid && out_ready && !load`: `out_valid <= 0`. `out_sum`/`out_carry` hold their last values.
- `ovf_count` increments by 1 on each load whose computed carry is 1. It saturates at 16'hFFFF and never wraps.
- Simultaneous push and pop are both performed. Occupancy is unchanged, and a full FIFO stays full, so `in_ready` stays 0 that cycle.
- A push into an empty FIFO is not bypassed. The pair becomes the head only after the edge that writes it.
- While `out_valid && !out_ready`, the output register holds and no pop occurs. The FIFO absorbs up to `DEPTH` further pairs, then deasserts `in_ready`.

## Timing

- Reset (async assert, synchronous-looking release on the next edge): both pointers 0, so `in_ready`=1. `out_valid`=0, `out_sum`=0, `out_carry`=0, `ovf_count`=0. `add_a`/`add_b` are 0 because the FIFO is empty.
- Reset mid-operation: all buffered pairs and any pending result are discarded. There is no output handshake completion during reset.
- Latency: a pair accepted at edge k, with the FIFO previously empty and the output free, is the head during cycle k..k+1, loads at edge k+1, and is visible with `out_valid`=1 after edge k+1. That is 1 cycle after acceptance.
- Throughput: 1 result/cycle when `out_ready` is held high and `in_valid` is continuous.
- The adder path (`add_a` → `add_y`) must settle within one clock period. The block adds only the compare after it.

## Test plan

1. Reset check: assert `rst` with `in_valid`=1 → `in_ready`=1, `out_valid`=0, `out_sum`=0, `ovf_count`=0 throughout reset; no result appears after release until a new push.
2. Single add with WIDTH=8: push a=8'h12, b=8'h34 at edge k with `out_ready`=1 → after edge k+1, `out_sum`=8'h46, `out_carry`=0, `out_valid`=1 for exactly one cycle.
3. Carry path: push 8'hFF+8'h01, then 8'h80+8'h80, then 8'h7F+8'h80 → sums 8'h00/8'h00/8'hFF, carries 1/1/0, `ovf_count`=2.
4. Backpressure with DEPTH=2: hold `out_ready`=0 and push 4 pairs → first result is held in the output register, FIFO holds 2, `in_ready`=0 after the third acceptance, and the fourth pair is not accepted. Release `out_ready` → results drain in order with no loss or duplication.
5. Streaming: 100 random pairs with `in_valid` and `out_ready` both continuously high → one result per cycle after the first; every `out_sum` equals (a+b) mod 256 and every `out_carry` equals bit 8 of a+b.
6. Saturation and reset mid-stream: force 65 540 carry results → `ovf_count` stops at 16'hFFFF. Then assert `rst` with 2 pairs buffered and `out_valid`=1 → everything clears to reset values and `ovf_count`=0.
